// File: rtl/mig_pkg.sv
// Shared definitions for the MIG truth-table sequencer: signal-space layout,
// operand/descriptor types and the sequencer state encoding.
package mig_pkg;

    localparam int unsigned MAJ_NUM_IN = 7;
    localparam int unsigned TT_W       = 128;
    localparam int unsigned SIG_CONST0 = 0;
    localparam int unsigned SIG_X_BASE = 1;
    localparam int unsigned SIG_G_BASE = 8;
    localparam int unsigned MIG_SIG_W  = 4;

    typedef struct packed {
        logic                 inv;
        logic [MIG_SIG_W-1:0] idx;
    } mig_operand_t;

    // op0 sits in the LSBs of a packed descriptor
    typedef struct packed {
        mig_operand_t op2;
        mig_operand_t op1;
        mig_operand_t op0;
    } mig_gate_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_CAPT,
        ST_DONE
    } mig_state_e;

    function automatic mig_operand_t mig_op(input logic inv, input logic [MIG_SIG_W-1:0] idx);
        mig_operand_t o;
        o.inv = inv;
        o.idx = idx;
        return o;
    endfunction

endpackage

// File: rtl/mig_tt_sequencer_alu.sv
// Operand resolve (index mux + optional invert) feeding a 3-input majority.
// Tying all three operands together turns it into a plain signal buffer.
module mig_maj_alu
    import mig_pkg::*;
#(
    parameter int unsigned SIG_W = 4
) (
    input  logic [2**SIG_W-1:0] sig_vec,
    input  logic [SIG_W:0]      op_a,
    input  logic [SIG_W:0]      op_b,
    input  logic [SIG_W:0]      op_c,
    output logic                maj
);

    logic a, b, c;

    always_comb begin
        a   = sig_vec[op_a[SIG_W-1:0]] ^ op_a[SIG_W];
        b   = sig_vec[op_b[SIG_W-1:0]] ^ op_b[SIG_W];
        c   = sig_vec[op_c[SIG_W-1:0]] ^ op_c[SIG_W];
        maj = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/mig_tt_sequencer.sv
// Sweeps all 128 input patterns through a programmable MIG, one gate per
// cycle on a shared majority unit, and hands out the resulting truth table.
module mig_tt_sequencer
    import mig_pkg::*;
#(
    parameter int unsigned MAX_GATES = 8,
    parameter int unsigned SIG_W     = 4,
    parameter int unsigned GA_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [GA_W-1:0]          cfg_addr,
    input  logic [3*(SIG_W+1)-1:0]   cfg_data,
    input  logic                     start,
    input  logic [GA_W:0]            num_gates,
    input  logic [SIG_W:0]           out_sel,
    output logic                     busy,
    output logic                     cfg_err,
    output logic                     tt_valid,
    input  logic                     tt_ready,
    output logic [TT_W-1:0]          tt_data
);

    localparam int unsigned NSIG  = 2**SIG_W;
    localparam int unsigned OP_W  = SIG_W + 1;
    localparam logic [GA_W:0] MAX_G = (GA_W+1)'(MAX_GATES);

    mig_state_e             state_q, state_d;
    logic [3*OP_W-1:0]      desc_q [MAX_GATES];
    logic [3*OP_W-1:0]      desc_d [MAX_GATES];
    logic [MAX_GATES-1:0]   gate_q, gate_d;
    logic [6:0]             p_q, p_d;
    logic [GA_W-1:0]        g_q, g_d;
    logic [GA_W:0]          ng_q, ng_d;
    logic [OP_W-1:0]        osel_q, osel_d;
    logic                   busy_q, busy_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   tt_valid_q, tt_valid_d;
    logic [TT_W-1:0]        tt_data_q, tt_data_d;

    logic [NSIG-1:0]        sig_vec;
    logic [3*OP_W-1:0]      cur_desc;
    logic                   gate_val;
    logic                   out_val;

    // Gate registers not yet written this pattern are still zero, so forward
    // and self references naturally resolve to 0.
    always_comb begin
        sig_vec = '0;
        for (int unsigned i = 0; i < MAJ_NUM_IN; i++) begin
            sig_vec[SIG_X_BASE+i] = p_q[i];
        end
        for (int unsigned g = 0; g < MAX_GATES; g++) begin
            if (SIG_G_BASE + g < NSIG) begin
                sig_vec[SIG_G_BASE+g] = gate_q[g];
            end
        end
    end

    assign cur_desc = desc_q[g_q];

    mig_maj_alu #(.SIG_W(SIG_W)) u_gate_alu (
        .sig_vec (sig_vec),
        .op_a    (cur_desc[OP_W-1:0]),
        .op_b    (cur_desc[2*OP_W-1:OP_W]),
        .op_c    (cur_desc[3*OP_W-1:2*OP_W]),
        .maj     (gate_val)
    );

    mig_maj_alu #(.SIG_W(SIG_W)) u_out_buf (
        .sig_vec (sig_vec),
        .op_a    (osel_q),
        .op_b    (osel_q),
        .op_c    (osel_q),
        .maj     (out_val)
    );

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        gate_d     = gate_q;
        p_d        = p_q;
        g_d        = g_q;
        ng_d       = ng_q;
        osel_d     = osel_q;
        busy_d     = busy_q;
        cfg_err_d  = 1'b0;
        tt_valid_d = tt_valid_q;
        tt_data_d  = tt_data_q;

        if (cfg_we && !busy_q && ({1'b0, cfg_addr} < MAX_G)) begin
            desc_d[cfg_addr] = cfg_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((num_gates != '0) && (num_gates <= MAX_G)) begin
                        ng_d    = num_gates;
                        osel_d  = out_sel;
                        p_d     = '0;
                        g_d     = '0;
                        gate_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ST_EVAL;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                gate_d[g_q] = gate_val;
                g_d         = g_q + 1'b1;
                if ({1'b0, g_q} == ng_q - 1'b1) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                tt_data_d[p_q] = out_val;
                gate_d         = '0;
                g_d            = '0;
                if (p_q == '1) begin
                    busy_d     = 1'b0;
                    tt_valid_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    p_d     = p_q + 7'd1;
                    state_d = ST_EVAL;
                end
            end
            ST_DONE: begin
                if (tt_ready) begin
                    tt_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            for (int unsigned i = 0; i < MAX_GATES; i++) begin
                desc_q[i] <= '0;
            end
            gate_q     <= '0;
            p_q        <= '0;
            g_q        <= '0;
            ng_q       <= '0;
            osel_q     <= '0;
            busy_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            tt_valid_q <= 1'b0;
            tt_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            gate_q     <= gate_d;
            p_q        <= p_d;
            g_q        <= g_d;
            ng_q       <= ng_d;
            osel_q     <= osel_d;
            busy_q     <= busy_d;
            cfg_err_q  <= cfg_err_d;
            tt_valid_q <= tt_valid_d;
            tt_data_q  <= tt_data_d;
        end
    end

    assign busy     = busy_q;
    assign cfg_err  = cfg_err_q;
    assign tt_valid = tt_valid_q;
    assign tt_data  = tt_data_q;

endmodule
